// File: rtl/branch_pred_ctrl_pkg.sv
// ============================================================================
// Module      : branch_pred_ctrl_pkg
// Description : Shared types and constants for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pred_ctrl_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_e;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam int unsigned PC_INC     = 4;

    // Saturating step: never wraps past the strong states.
    function automatic ctr_state_e sat_step(input ctr_state_e s, input logic inc);
        ctr_state_e n;
        n = s;
        if (inc) begin
            if (s != ST)  n = ctr_state_e'(s + 2'd1);
        end else begin
            if (s != SNT) n = ctr_state_e'(s - 2'd1);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_pred_ctrl_sat_counter_table.sv
// ============================================================================
// Module      : sat_counter_table
// Description : 2^IDX_BITS x 2-bit saturating counters, async read, sync update.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter_table
    import branch_pred_ctrl_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output logic [1:0]          rd_ctr_o,
    input  logic                upd_en_i,
    input  logic [IDX_BITS-1:0] upd_idx_i,
    input  logic                upd_taken_i
);

    localparam int DEPTH = 1 << IDX_BITS;

    ctr_state_e ctr_q [DEPTH];
    ctr_state_e ctr_d;

    // Read is the registered value, so a same-cycle update is not bypassed.
    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_comb begin
        ctr_d = sat_step(ctr_q[upd_idx_i], upd_taken_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= WNT;
            end
        end else if (upd_en_i) begin
            ctr_q[upd_idx_i] <= ctr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_pred_ctrl.sv
// ============================================================================
// Module      : branch_pred_ctrl
// Description : ID-stage branch prediction and EX-stage resolution/statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            id_valid,
    input  logic            id_is_branch,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_target,
    output logic            id_pred_taken,
    output logic            id_redirect,
    output logic [XLEN-1:0] id_redirect_pc,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    output logic            ex_mispredict,
    output logic [XLEN-1:0] ex_redirect_pc,
    output logic            flush_if,
    output logic            flush_id,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    logic [IDX_BITS-1:0] idx_id;
    logic [IDX_BITS-1:0] idx_ex;
    logic [1:0]          id_ctr;
    logic                res;
    logic [31:0]         stat_branches_q;
    logic [31:0]         stat_branches_d;
    logic [31:0]         stat_mispredicts_q;
    logic [31:0]         stat_mispredicts_d;
    logic                w_unused_pc_bits;

    assign idx_id = id_pc[IDX_BITS+1:2];
    assign idx_ex = ex_pc[IDX_BITS+1:2];
    assign w_unused_pc_bits = ^{id_pc[XLEN-1:IDX_BITS+2], id_pc[1:0],
                                ex_pc[XLEN-1:IDX_BITS+2], ex_pc[1:0]};

    sat_counter_table #(
        .IDX_BITS (IDX_BITS)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (idx_id),
        .rd_ctr_o    (id_ctr),
        .upd_en_i    (res),
        .upd_idx_i   (idx_ex),
        .upd_taken_i (ex_taken)
    );

    // Reset masks resolution so no update or flush leaks out during rst.
    assign res            = ex_valid & ex_is_branch & ~stall & ~rst;
    assign ex_mispredict  = res & (ex_taken != ex_pred_taken);
    assign ex_redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(PC_INC);
    assign flush_if       = ex_mispredict;
    assign flush_id       = ex_mispredict;

    // A mispredict in EX means the ID instruction is wrong-path.
    assign id_pred_taken  = id_valid & id_is_branch & id_ctr[1] & ~rst;
    assign id_redirect    = id_pred_taken & ~ex_mispredict;
    assign id_redirect_pc = id_target;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (res)           stat_branches_d    = stat_branches_q + 32'd1;
        if (ex_mispredict) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
// ============================================================================
// Module      : tb_branch_pred_ctrl
// Description : Directed self-checking bench for branch_pred_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_pred_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        id_valid;
    logic        id_is_branch;
    logic [31:0] id_pc;
    logic [31:0] id_target;
    logic        id_pred_taken;
    logic        id_redirect;
    logic [31:0] id_redirect_pc;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic        ex_pred_taken;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_pred_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .id_valid         (id_valid),
        .id_is_branch     (id_is_branch),
        .id_pc            (id_pc),
        .id_target        (id_target),
        .id_pred_taken    (id_pred_taken),
        .id_redirect      (id_redirect),
        .id_redirect_pc   (id_redirect_pc),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_taken         (ex_taken),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_mispredict    (ex_mispredict),
        .ex_redirect_pc   (ex_redirect_pc),
        .flush_if         (flush_if),
        .flush_id         (flush_id),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic br, input logic tk, input logic pr,
                          input logic [31:0] pc, input logic [31:0] tgt);
        ex_valid = v; ex_is_branch = br; ex_taken = tk; ex_pred_taken = pr;
        ex_pc = pc; ex_target = tgt;
    endtask

    task automatic set_id(input logic [31:0] pc);
        id_valid = 1'b1; id_is_branch = 1'b1; id_pc = pc; id_target = pc + 32'h40;
    endtask

    // Drive on negedge, sample combinational outputs 1ns later, commit at posedge.
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        set_id(32'h100);
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200);
        @(negedge clk); #1;
        check("rst_mispredict", {31'd0, ex_mispredict}, 32'd0);
        check("rst_flush",      {30'd0, flush_if, flush_id}, 32'd0);
        check("rst_pred",       {30'd0, id_pred_taken, id_redirect}, 32'd0);
        step();
        rst = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        // Fresh table: weak not-taken everywhere.
        check("init_pred",     {31'd0, id_pred_taken}, 32'd0);
        check("init_redirect", {31'd0, id_redirect}, 32'd0);
        check("init_branches", stat_branches, 32'd0);
        check("init_mispred",  stat_mispredicts, 32'd0);

        // First resolve: predicted NT, actually taken.
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200);
        #1;
        check("m1_mispredict", {31'd0, ex_mispredict}, 32'd1);
        check("m1_redir_pc",   ex_redirect_pc, 32'h200);
        check("m1_flush",      {30'd0, flush_if, flush_id}, 32'd3);
        check("m1_id_old",     {31'd0, id_pred_taken}, 32'd0);
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("m1_pred_after", {31'd0, id_pred_taken}, 32'd1);
        check("m1_redir_after",{31'd0, id_redirect}, 32'd1);
        check("m1_redir_tgt",  id_redirect_pc, 32'h140);
        check("m1_stats",      {stat_branches[15:0], stat_mispredicts[15:0]}, {16'd1, 16'd1});

        // Three correct taken resolves: counter 10 -> 11 and stays at 11.
        set_ex(1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200);
        #1;
        check("t_no_mispred", {31'd0, ex_mispredict}, 32'd0);
        step(); step(); step();
        // Not-taken while predicted taken: 11 -> 10.
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200);
        #1;
        check("nt_mispredict", {31'd0, ex_mispredict}, 32'd1);
        check("nt_redir_pc",   ex_redirect_pc, 32'h104);
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("sat_pred_10",   {31'd0, id_pred_taken}, 32'd1);
        check("sat_branches",  stat_branches, 32'd5);
        check("sat_mispred",   stat_mispredicts, 32'd2);
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h200);
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("sat_pred_01",   {31'd0, id_pred_taken}, 32'd0);
        check("stats_6_3",     {stat_branches[15:0], stat_mispredicts[15:0]}, {16'd6, 16'd3});

        // Bring index 0 back to 10, then collide ID redirect with an EX mispredict.
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200);
        step();
        set_id(32'h300);
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h180, 32'h280);
        #1;
        check("prio_id_pred",    {31'd0, id_pred_taken}, 32'd1);
        check("prio_id_redir",   {31'd0, id_redirect}, 32'd0);
        check("prio_mispredict", {31'd0, ex_mispredict}, 32'd1);
        check("prio_redir_pc",   ex_redirect_pc, 32'h184);
        step();
        // Index 0x20 is now 00; stats 8/5.

        // Stall holds back a mispredicting resolve.
        stall = 1'b1;
        set_id(32'h100);
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h180, 32'h280);
        #1;
        check("stall_mispredict", {31'd0, ex_mispredict}, 32'd0);
        check("stall_flush",      {30'd0, flush_if, flush_id}, 32'd0);
        check("stall_id_pred",    {31'd0, id_pred_taken}, 32'd1);
        step(); step();
        set_id(32'h180);
        #1;
        check("stall_ctr_hold", {31'd0, id_pred_taken}, 32'd0);
        check("stall_stats",    {stat_branches[15:0], stat_mispredicts[15:0]}, {16'd8, 16'd5});
        stall = 1'b0;
        #1;
        check("unstall_mispredict", {31'd0, ex_mispredict}, 32'd1);
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("unstall_stats", {stat_branches[15:0], stat_mispredicts[15:0]}, {16'd9, 16'd6});
        check("unstall_ctr_01",{31'd0, id_pred_taken}, 32'd0);

        // Non-branch and invalid EX: no flush, no count.
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 32'h180, 32'h280);
        #1;
        check("nonbr_mispredict", {31'd0, ex_mispredict}, 32'd0);
        step();
        set_ex(1'b0, 1'b1, 1'b1, 1'b0, 32'h180, 32'h280);
        #1;
        check("inval_mispredict", {31'd0, ex_mispredict}, 32'd0);
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("nonbr_stats", {stat_branches[15:0], stat_mispredicts[15:0]}, {16'd9, 16'd6});
        check("nonbr_ctr",   {31'd0, id_pred_taken}, 32'd0);

        // PC+4 wraps at the top of the address space.
        set_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1000);
        #1;
        check("wrap_mispredict", {31'd0, ex_mispredict}, 32'd1);
        check("wrap_redir_pc",   ex_redirect_pc, 32'h0000_0000);
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("wrap_stats", {stat_branches[15:0], stat_mispredicts[15:0]}, {16'd10, 16'd7});

        // Mid-run reset with a pending mispredicting resolve.
        rst = 1'b1;
        set_id(32'h100);
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h180, 32'h280);
        #1;
        check("mrst_outputs", {28'd0, ex_mispredict, flush_if, id_pred_taken, id_redirect}, 32'd0);
        step();
        rst = 1'b0;
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("mrst_stats",  {stat_branches[15:0], stat_mispredicts[15:0]}, 32'd0);
        check("mrst_ctr_0",  {31'd0, id_pred_taken}, 32'd0);
        // One taken resolve from 01 must reach 10 (reset value is weak, not strong).
        set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200);
        step();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("mrst_ctr_wnt", {31'd0, id_pred_taken}, 32'd1);
        set_id(32'h180);
        #1;
        check("mrst_idx20_wnt", {31'd0, id_pred_taken}, 32'd0);
        check("mrst_stats_1",   {stat_branches[15:0], stat_mispredicts[15:0]}, {16'd1, 16'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
- Branch prediction and resolution controller for the RV32I pipeline.
- In ID it predicts conditional branches with a table of 2-bit saturating counters and redirects fetch to the branch target on a predicted-taken branch.
- In EX it compares the comparator's branch outcome against the carried prediction. On a mismatch it drives the fetch redirect and the IF/ID flushes, updates the counter table, and keeps branch and mispredict statistics.

Parameters:
- IDX_BITS, 6: counter-table index width; the table has 2^IDX_BITS entries.
- XLEN, 32: PC and target width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  pipeline hold; freezes table and statistics updates, qualifies EX resolution
- id_valid  in  1  ID stage holds a live instruction
- id_is_branch  in  1  ID instruction is a conditional branch (BRANCH opcode)
- id_pc  in  XLEN  PC of ID instruction
- id_target  in  XLEN  computed branch target (pc + B-immediate)
- id_pred_taken  out  1  prediction; carried down the pipe to EX
- id_redirect  out  1  fetch redirect to id_target
- id_redirect_pc  out  XLEN  equals id_target
- ex_valid  in  1  EX stage holds a live instruction
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_taken  in  1  branch comparator result for the EX instruction
- ex_pred_taken  in  1  prediction made for this instruction in ID
- ex_pc  in  XLEN  PC of EX instruction
- ex_target  in  XLEN  branch target of EX instruction
- ex_mispredict  out  1  prediction wrong; redirect fetch
- ex_redirect_pc  out  XLEN  corrected PC
- flush_if  out  1  kill IF/ID register contents
- flush_id  out  1  kill ID/EX register contents
- stat_branches  out  32  resolved branch count
- stat_mispredicts  out  32  mispredict count

Behaviour:
- Index: idx = pc[IDX_BITS+1:2]. Lookup uses id_pc; update uses ex_pc.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken when bit1 = 1.
- Reset (rst=1 at clock edge):
  - all counters become 01;
  - stat_branches and stat_mispredicts become 0;
  - takes effect even mid-operation; any pending update in that cycle is discarded.
- Output values while rst=1:
  - ex_mispredict, flush_if, flush_id, id_redirect and id_pred_taken are 0;
  - id_redirect_pc and ex_redirect_pc are don't-care.
- ID prediction (combinational, 0-cycle):
  - id_pred_taken = id_valid & id_is_branch & ctr[idx_id][1];
  - id_redirect = id_pred_taken & ~ex_mispredict.
- EX resolve (combinational):
  - res = ex_valid & ex_is_branch & ~stall;
  - ex_mispredict = res & (ex_taken != ex_pred_taken);
  - ex_redirect_pc = ex_taken ? ex_target : ex_pc + 4, with the add mod 2^XLEN (wrap-around allowed);
  - flush_if = flush_id = ex_mispredict.
- Priority: an EX mispredict overrides any ID redirect in the same cycle. The ID instruction is wrong-path and is being flushed.
- Table update (registered, 1 cycle): when res=1, ctr[idx_ex] increments on ex_taken and decrements otherwise. It saturates at 11 and 00 (no wrap).
- Same-cycle lookup/update on the same index: ID reads the pre-update (old) value; no bypass.
- Statistics: on res, stat_branches += 1; on ex_mispredict, stat_mispredicts += 1. Both are 32-bit and wrap from FFFF_FFFF to 0.
- Stall: no table or statistics change, no redirect or flush from EX. ID prediction outputs remain combinationally valid.
- Non-branch or invalid EX: no update, no flush.

Decomposition:
- Shared package:
  - counter-state typedef (2-bit enum: SNT, WNT, WT, ST);
  - BRANCH opcode constant 7'b1100011;
  - PC increment constant 4.
- One sub-module: sat_counter_table (2^IDX_BITS x 2-bit array, one async read port, one sync update port with saturating inc/dec, synchronous reset to WNT).

Test Plan:
- Reset then ID branch at id_pc=0x100 -> id_pred_taken=0, id_redirect=0; stat_branches=0.
- EX branch pc=0x100, pred=0, taken=1, target=0x200 -> ex_mispredict=1, ex_redirect_pc=0x200, flush_if=flush_id=1. Next cycle, ID lookup of 0x100 gives id_pred_taken=1 (counter 10).
- Four taken resolves at pc=0x100, then one not-taken resolve with pred=1 -> counter reads 11 after saturation, then 10. Mispredict with ex_redirect_pc=0x104. stat_branches=5, stat_mispredicts=2 (first and last).
- Same cycle: ID predicted-taken at 0x300 and EX mispredict at 0x100 -> id_redirect=0, ex_mispredict=1.
- stall=1 with a mispredicting EX branch -> ex_mispredict=0, counters and stats unchanged. Deassert stall -> mispredict fires once, stats +1.
- ex_pc=0xFFFF_FFFC, not-taken mispredict -> ex_redirect_pc=0x0000_0000. Then rst mid-run -> all counters 01, stats 0.
